instr_loader: RTL and testbench

Boot-time program loader: the write-side counterpart of the instruction memory the single-cycle core reads. It accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them into instruction memory at the addresses the PC will fetch. While loading, it holds the core in reset. When the image is complete, it releases the core so execution starts at BASE_ADDR.

---
 rtl/instr_loader.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_instr_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: boot-time program loader.
//
// Receives a byte stream over a valid/ready handshake, assembles 16-bit
// instruction words and writes them into instruction memory at the
// addresses the core's PC will fetch (BASE_ADDR, BASE_ADDR+ADDR_STRIDE, ...).
// The core is held in reset until the whole image has been written.
//
// Stream format: len_lo, len_hi (word count N, little-endian), then N words,
// each sent low byte first. With LOADER_CHECKSUM_EN defined, one trailing
// byte follows that must equal the XOR of every preceding byte.
//
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CHK state).
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      one-cycle pulse that begins a load (ignored while busy)
//   in_data    stream byte
//   in_valid   in_data is valid
//   in_ready   loader accepts a byte this cycle
//   imem_we    instruction memory write enable (one cycle per word)
//   imem_addr  instruction memory write address
//   imem_wd    instruction memory write data {hi, lo}
//   cpu_rst    active-high reset to the core (low only in DONE)
//   busy       load in progress
//   done       image loaded, core released
//   err        load aborted (length too large or bad checksum)
module instr_loader #(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter logic [15:0] ADDR_STRIDE = 16'd4,
  parameter int          DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [15:0] imem_addr,
  output logic [15:0] imem_wd,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LEN_LO  = 4'd1,
    S_LEN_HI  = 4'd2,
    S_DATA_LO = 4'd3,
    S_DATA_HI = 4'd4,
    S_WRITE   = 4'd5,
`ifdef LOADER_CHECKSUM_EN
    S_CHK     = 4'd6,
`endif
    S_DONE    = 4'd7,
    S_ERR     = 4'd8
  } state_t;

  // State entered once the image body is complete (N=0 or last word written).
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_LAST = S_CHK;
`else
  localparam state_t S_LAST = S_DONE;
`endif

  localparam logic [15:0] DEPTH_LIMIT = 16'(DEPTH_WORDS);

  state_t      state_r;
  state_t      state_s;
  logic [7:0]  len_lo_r;
  logic [15:0] cnt_r;
  logic [15:0] addr_r;
  logic [7:0]  lo_r;
  logic [7:0]  hi_r;
  logic [15:0] len_s;
  logic        accept_s;

  logic        in_ready_r;
  logic        imem_we_r;
  logic        cpu_rst_r;
  logic        busy_r;
  logic        done_r;
  logic        err_r;

  logic        in_ready_s;
  logic        imem_we_s;
  logic        cpu_rst_s;
  logic        busy_s;
  logic        done_s;
  logic        err_s;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_r;

  // Running XOR checksum update over one accepted byte.
  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  // in_ready_r always mirrors the decode of state_r, so the handshake uses
  // only registered information from this side.
  assign accept_s = in_valid & in_ready_r;
  assign len_s    = {in_data, len_lo_r};

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) state_s = S_LEN_LO;
        else       state_s = state_r;
      end
      S_LEN_LO: begin
        if (accept_s) state_s = S_LEN_HI;
        else          state_s = state_r;
      end
      S_LEN_HI: begin
        if (accept_s) begin
          if (len_s > DEPTH_LIMIT)  state_s = S_ERR;
          else if (len_s == 16'd0)  state_s = S_LAST;
          else                      state_s = S_DATA_LO;
        end else begin
          state_s = state_r;
        end
      end
      S_DATA_LO: begin
        if (accept_s) state_s = S_DATA_HI;
        else          state_s = state_r;
      end
      S_DATA_HI: begin
        if (accept_s) state_s = S_WRITE;
        else          state_s = state_r;
      end
      S_WRITE: begin
        // cnt_r still holds the count including the word being written now.
        if (cnt_r == 16'd1) state_s = S_LAST;
        else                state_s = S_DATA_LO;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (accept_s) begin
          if (in_data == csum_r) state_s = S_DONE;
          else                   state_s = S_ERR;
        end else begin
          state_s = state_r;
        end
      end
`endif
      default: state_s = S_IDLE;
    endcase
  end

  // Output decode of the next state; registered below so outputs change
  // together with the state register.
  always_comb begin
    in_ready_s = 1'b0;
    imem_we_s  = 1'b0;
    cpu_rst_s  = 1'b1;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    err_s      = 1'b0;
    case (state_s)
      S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b1;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b1;
      end
`endif
      S_WRITE: begin
        imem_we_s = 1'b1;
        busy_s    = 1'b1;
      end
      S_DONE: begin
        cpu_rst_s = 1'b0;
        done_s    = 1'b1;
      end
      S_ERR: begin
        err_s = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      in_ready_r <= 1'b0;
      imem_we_r  <= 1'b0;
      cpu_rst_r  <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      in_ready_r <= in_ready_s;
      imem_we_r  <= imem_we_s;
      cpu_rst_r  <= cpu_rst_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      err_r      <= err_s;
    end
  end

  // Datapath: length capture, byte assembly, address/count, checksum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo_r <= 8'h00;
      cnt_r    <= 16'h0000;
      addr_r   <= BASE_ADDR;
      lo_r     <= 8'h00;
      hi_r     <= 8'h00;
`ifdef LOADER_CHECKSUM_EN
      csum_r   <= 8'h00;
`endif
    end else begin
      case (state_r)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            addr_r <= BASE_ADDR;
            cnt_r  <= 16'h0000;
`ifdef LOADER_CHECKSUM_EN
            csum_r <= 8'h00;
`endif
          end
        end
        S_LEN_LO: begin
          if (accept_s) begin
            len_lo_r <= in_data;
`ifdef LOADER_CHECKSUM_EN
            csum_r   <= csum_next(csum_r, in_data);
`endif
          end
        end
        S_LEN_HI: begin
          if (accept_s) begin
            cnt_r  <= len_s;
`ifdef LOADER_CHECKSUM_EN
            csum_r <= csum_next(csum_r, in_data);
`endif
          end
        end
        S_DATA_LO: begin
          if (accept_s) begin
            lo_r   <= in_data;
`ifdef LOADER_CHECKSUM_EN
            csum_r <= csum_next(csum_r, in_data);
`endif
          end
        end
        S_DATA_HI: begin
          if (accept_s) begin
            hi_r   <= in_data;
`ifdef LOADER_CHECKSUM_EN
            csum_r <= csum_next(csum_r, in_data);
`endif
          end
        end
        S_WRITE: begin
          // Address wraps naturally at 16 bits.
          addr_r <= addr_r + ADDR_STRIDE;
          cnt_r  <= cnt_r - 16'd1;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign imem_we   = imem_we_r;
  assign imem_addr = addr_r;
  assign imem_wd   = {hi_r, lo_r};
  assign cpu_rst   = cpu_rst_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader. Each load is described as an image
// (list of words) plus per-byte idle gaps; the expected write list, final
// status and completion cycle are derived directly from the stream format.
module tb_instr_loader;

  localparam logic [15:0] BASE = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wd;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] img[$];

  instr_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wd   (imem_wd),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " flags"}, {in_ready, imem_we, cpu_rst, busy, done, err}, 6'b001000);
    check_eq({tag, " addr"}, imem_addr, BASE);
    check_eq({tag, " wd"}, imem_wd, 16'h0000);
  endtask

  // Runs one load of the words in img with length field n_field.
  task automatic run_load(input string name, input int n_field, input int stall_max,
                          input bit fixed3, input bit start_poke, input bit bad_csum,
                          input bit abort_rst);
    logic [7:0]  bq[$];
    int          sq[$];
    logic [15:0] ea[$];
    logic [15:0] ed[$];
    logic [7:0]  cs;
    int          stall_sum;
    int          exp_cycle;
    bit          exp_err;
    int          cyc;
    int          consumed;
    bit          aborted;

    exp_err = (n_field > 256);
    bq.push_back(8'(n_field));      sq.push_back(0);
    bq.push_back(8'(n_field >> 8)); sq.push_back(0);
    if (!exp_err) begin
      foreach (img[i]) begin
        bq.push_back(img[i][7:0]);
        sq.push_back(fixed3 ? 3 : int'($urandom_range(stall_max, 0)));
        bq.push_back(img[i][15:8]);
        sq.push_back(fixed3 ? 3 : int'($urandom_range(stall_max, 0)));
        ea.push_back(BASE + 16'(4 * i));
        ed.push_back(img[i]);
      end
    end
`ifdef LOADER_CHECKSUM_EN
    if (!exp_err) begin
      cs = 8'h00;
      foreach (bq[k]) cs = cs ^ bq[k];
      if (bad_csum) cs = cs ^ 8'(1 << $urandom_range(7, 0));
      bq.push_back(cs);
      sq.push_back(fixed3 ? 3 : int'($urandom_range(stall_max, 0)));
      exp_err = bad_csum;
    end
`endif
    stall_sum = 0;
    foreach (sq[k]) stall_sum += sq[k];
    if (n_field > 256) exp_cycle = 3;
    else begin
      exp_cycle = 3 + 3 * img.size() + stall_sum;
`ifdef LOADER_CHECKSUM_EN
      exp_cycle += 1;
`endif
    end

    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start    = 1'b0;
    cyc      = 1;
    consumed = 0;
    aborted  = 1'b0;
    check_eq({name, " cycle1 cpu_rst/busy"}, {cpu_rst, busy, done}, 3'b110);
    while (cyc < 4000) begin
      if (imem_we) begin
        if (ea.size() == 0) check_eq({name, " unexpected write"}, 1, 0);
        else begin
          check_eq({name, " addr"}, imem_addr, ea.pop_front());
          check_eq({name, " data"}, imem_wd, ed.pop_front());
        end
        if (abort_rst) begin
          #2 rst = 1'b1;
          #1 check_reset_outputs({name, " async rst"});
          aborted = 1'b1;
          break;
        end
      end
      if (done || err) break;
      start = start_poke && (consumed == 3);
      if (bq.size() == 0) begin
        in_valid = 1'b0;
      end else if (sq[0] > 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (in_ready) sq[0] = sq[0] - 1;
      end else begin
        in_valid = 1'b1;
        in_data  = bq[0];
        if (in_ready) begin
          void'(bq.pop_front());
          void'(sq.pop_front());
          consumed++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;

    if (aborted) begin
      @(negedge clk);
      rst = 1'b0;
    end else begin
      check_eq({name, " timeout"}, (cyc < 4000), 1);
      check_eq({name, " cycle"}, cyc, exp_cycle);
      check_eq({name, " done/err/cpu_rst/busy"}, {done, err, cpu_rst, busy},
               {~exp_err, exp_err, exp_err, 1'b0});
      check_eq({name, " writes left"}, ea.size(), 0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    img = '{16'h1234, 16'hABCD};
    run_load("basic", 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_load("stall3", 2, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_load("start_in_dhi", 2, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    img.delete();
    run_load("n0", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_load("n257", 257, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    img = '{16'h1234, 16'hABCD};
    run_load("after_err", 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_load("abort", 2, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_load("after_abort", 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    run_load("bad_csum", 2, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_load("after_bad_csum", 2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    for (int t = 0; t < 6; t++) begin
      img.delete();
      for (int w = 0; w < int'($urandom_range(6, 1)); w++) img.push_back(16'($urandom));
      run_load("random", img.size(), 3, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    img.delete();
    for (int w = 0; w < 256; w++) img.push_back(16'($urandom));
    run_load("n256", 256, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
